// File: rtl/alu_pkg.sv
// Shared definitions for the ALU / multiply-divide execute unit:
// operation codes, handshake FSM states and operation-class predicates.
package alu_pkg;

    typedef enum logic [4:0] {
        OP_ADD    = 5'd0,
        OP_SUB    = 5'd1,
        OP_AND    = 5'd2,
        OP_OR     = 5'd3,
        OP_XOR    = 5'd4,
        OP_SLL    = 5'd5,
        OP_SRL    = 5'd6,
        OP_SRA    = 5'd7,
        OP_SLT    = 5'd8,
        OP_SLTU   = 5'd9,
        OP_MUL    = 5'd16,
        OP_MULH   = 5'd17,
        OP_MULHSU = 5'd18,
        OP_MULHU  = 5'd19,
        OP_DIV    = 5'd20,
        OP_DIVU   = 5'd21,
        OP_REM    = 5'd22,
        OP_REMU   = 5'd23
    } aluop_t;

    typedef enum logic [2:0] {
        IDLE,
        MUL,
        DIV,
        FIX,
        DONE
    } state_t;

    // Multiply/divide codes occupy 16..23 and use the iterative engine.
    function automatic logic is_iter(input logic [4:0] op);
        return (op[4:3] == 2'b10);
    endfunction

    // Operand 1 is interpreted as two's complement for these codes.
    function automatic logic is_signed_a(input logic [4:0] op);
        return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
               (op == OP_DIV) || (op == OP_REM);
    endfunction

    // Operand 2 is interpreted as two's complement for these codes.
    function automatic logic is_signed_b(input logic [4:0] op);
        return (op == OP_MUL) || (op == OP_MULH) ||
               (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/alu_muldiv_core.sv
// Iterative multiply/divide engine: shift-add multiply and restoring
// divide on operand magnitudes, one bit per cycle, with the sign
// correction applied combinationally on the held result.
module alu_muldiv_core
    import alu_pkg::*;
#(
    parameter int D_WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [4:0]         op,
    input  logic [D_WIDTH-1:0] a,
    input  logic [D_WIDTH-1:0] b,
    output logic               done,
    output logic [D_WIDTH-1:0] result
);

    localparam int CW = $clog2(D_WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(D_WIDTH - 1);

    logic               running;
    logic               div_mode;
    logic               neg_q;
    logic               neg_r;
    logic               sel_high;
    logic               sel_rem;
    logic [CW-1:0]      count;
    logic [D_WIDTH-1:0] hi;
    logic [D_WIDTH-1:0] lo;
    logic [D_WIDTH-1:0] m;

    logic               a_neg;
    logic               b_neg;
    logic [D_WIDTH-1:0] a_mag;
    logic [D_WIDTH-1:0] b_mag;
    logic [D_WIDTH:0]   mul_sum;
    logic [D_WIDTH:0]   shifted;
    logic [D_WIDTH-1:0] diff;
    logic               fits;
    logic [2*D_WIDTH-1:0] prod_s;
    logic [D_WIDTH-1:0] q_s;
    logic [D_WIDTH-1:0] r_s;

    assign a_neg = is_signed_a(op) && a[D_WIDTH-1];
    assign b_neg = is_signed_b(op) && b[D_WIDTH-1];
    assign a_mag = a_neg ? (~a + 1'b1) : a;
    assign b_mag = b_neg ? (~b + 1'b1) : b;

    // Multiply step: conditionally add the multiplicand into the upper half.
    assign mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, m} : '0);

    // Divide step: bring in the next dividend bit and trial-subtract.
    assign shifted = {hi, lo[D_WIDTH-1]};
    assign fits    = (shifted >= {1'b0, m});
    assign diff    = shifted[D_WIDTH-1:0] - m;

    assign done = running && (count == LAST);

    // Load magnitudes on start, then advance one bit per cycle until the last step.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            running  <= 1'b0;
            div_mode <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            sel_high <= 1'b0;
            sel_rem  <= 1'b0;
            count    <= '0;
            hi       <= '0;
            lo       <= '0;
            m        <= '0;
        end else if (start) begin
            running  <= 1'b1;
            div_mode <= op[2];
            neg_q    <= a_neg ^ b_neg;
            neg_r    <= a_neg;
            sel_high <= (op[1:0] != 2'b00);
            sel_rem  <= op[1];
            count    <= '0;
            hi       <= '0;
            lo       <= a_mag;
            m        <= b_mag;
        end else if (running) begin
            count <= count + 1'b1;
            if (done) begin
                running <= 1'b0;
            end
            if (div_mode) begin
                hi <= fits ? diff : shifted[D_WIDTH-1:0];
                lo <= {lo[D_WIDTH-2:0], fits};
            end else begin
                hi <= mul_sum[D_WIDTH:1];
                lo <= {mul_sum[0], lo[D_WIDTH-1:1]};
            end
        end
    end

    // Sign fix-up and half/quotient/remainder selection of the held result.
    always_comb begin
        prod_s = neg_q ? (~{hi, lo} + 1'b1) : {hi, lo};
        q_s    = neg_q ? (~lo + 1'b1) : lo;
        r_s    = neg_r ? (~hi + 1'b1) : hi;
        result = '0;
        if (div_mode) begin
            result = sel_rem ? r_s : q_s;
        end else begin
            result = sel_high ? prod_s[2*D_WIDTH-1:D_WIDTH] : prod_s[D_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/alu_mdu.sv
// Execute-stage ALU with valid/ready handshake, registered results and
// flags, and an iterative RV32M-style multiply/divide engine.
module alu_mdu
    import alu_pkg::*;
#(
    parameter int D_WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               alusrc,
    input  logic [4:0]         aluctrl,
    input  logic [D_WIDTH-1:0] aluop1,
    input  logic [D_WIDTH-1:0] immop,
    input  logic [D_WIDTH-1:0] regop2,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [D_WIDTH-1:0] aluout,
    output logic               eq,
    output logic               lt,
    output logic               ltu
);

    localparam int SH_W = $clog2(D_WIDTH);
    localparam logic [D_WIDTH-1:0] MOST_NEG = {1'b1, {(D_WIDTH-1){1'b0}}};

    state_t             state;
    state_t             state_next;
    logic               captured;
    logic [4:0]         op_q;
    logic [D_WIDTH-1:0] a_q;
    logic [D_WIDTH-1:0] b_q;

    logic               accept;
    logic               dispatch;
    logic               iter_op;
    logic               special;
    logic               core_start;
    logic               core_done;
    logic [D_WIDTH-1:0] core_result;
    logic [D_WIDTH-1:0] single_res;
    logic [D_WIDTH-1:0] special_res;
    logic [SH_W-1:0]    sh;
    logic               eq_c;
    logic               lt_c;
    logic               ltu_c;
    logic               div_zero;
    logic               div_ovf;

    assign in_ready = (state == IDLE) && !captured;
    assign accept   = in_valid && in_ready;
    assign dispatch = (state == IDLE) && captured;

    assign sh    = b_q[SH_W-1:0];
    assign eq_c  = (a_q == b_q);
    assign lt_c  = ($signed(a_q) < $signed(b_q));
    assign ltu_c = (a_q < b_q);

    assign iter_op  = is_iter(op_q);
    assign div_zero = (b_q == '0);
    assign div_ovf  = is_signed_b(op_q) && (a_q == MOST_NEG) && (b_q == '1);
    assign special  = iter_op && op_q[2] && (div_zero || div_ovf);

    // Single-cycle results, plus the divide special cases that bypass iteration.
    always_comb begin
        single_res = '0;
        case (op_q)
            OP_ADD:  single_res = a_q + b_q;
            OP_SUB:  single_res = a_q - b_q;
            OP_AND:  single_res = a_q & b_q;
            OP_OR:   single_res = a_q | b_q;
            OP_XOR:  single_res = a_q ^ b_q;
            OP_SLL:  single_res = a_q << sh;
            OP_SRL:  single_res = a_q >> sh;
            OP_SRA:  single_res = $signed(a_q) >>> sh;
            OP_SLT:  single_res = {{(D_WIDTH-1){1'b0}}, lt_c};
            OP_SLTU: single_res = {{(D_WIDTH-1){1'b0}}, ltu_c};
            default: single_res = '0;
        endcase
        special_res = '0;
        if (div_zero) begin
            special_res = op_q[1] ? a_q : '1;
        end else begin
            special_res = op_q[1] ? '0 : MOST_NEG;
        end
    end

    // Handshake FSM next-state logic and engine start pulse.
    always_comb begin
        state_next = state;
        core_start = 1'b0;
        case (state)
            IDLE: begin
                if (captured) begin
                    if (iter_op && !special) begin
                        state_next = op_q[2] ? DIV : MUL;
                        core_start = 1'b1;
                    end else begin
                        state_next = DONE;
                    end
                end
            end
            MUL, DIV: begin
                if (core_done) begin
                    state_next = FIX;
                end
            end
            FIX:  state_next = DONE;
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Operand capture on accept and output registers written on completion.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            captured  <= 1'b0;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            aluout    <= '0;
            eq        <= 1'b0;
            lt        <= 1'b0;
            ltu       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            if (accept) begin
                captured <= 1'b1;
                op_q     <= aluctrl;
                a_q      <= aluop1;
                b_q      <= alusrc ? immop : regop2;
            end
            if (dispatch) begin
                captured <= 1'b0;
                eq       <= eq_c;
                lt       <= lt_c;
                ltu      <= ltu_c;
                if (!iter_op || special) begin
                    aluout    <= iter_op ? special_res : single_res;
                    out_valid <= 1'b1;
                end
            end
            if (state == FIX) begin
                aluout    <= core_result;
                out_valid <= 1'b1;
            end
            if ((state == DONE) && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    alu_muldiv_core #(
        .D_WIDTH(D_WIDTH)
    ) u_core (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (core_start),
        .op     (op_q),
        .a      (a_q),
        .b      (b_q),
        .done   (core_done),
        .result (core_result)
    );

endmodule

// File: tb/tb_alu_mdu.sv
// Self-checking bench for alu_mdu: directed cases plus randomized
// operations compared against an arithmetic reference model.
module tb_alu_mdu;
    import alu_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         alusrc = 1'b0;
    logic         out_ready = 1'b1;
    logic [4:0]   aluctrl = '0;
    logic [W-1:0] aluop1 = '0;
    logic [W-1:0] immop = '0;
    logic [W-1:0] regop2 = '0;
    logic         in_ready;
    logic         out_valid;
    logic         eq;
    logic         lt;
    logic         ltu;
    logic [W-1:0] aluout;

    int checks = 0;
    int errors = 0;

    logic [4:0] op_list [0:21] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7,
                                   5'd8, 5'd9, 5'd16, 5'd17, 5'd18, 5'd19, 5'd20,
                                   5'd21, 5'd22, 5'd23, 5'd12, 5'd15, 5'd26, 5'd31};

    always #5 clk = ~clk;

    alu_mdu #(.D_WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alusrc    (alusrc),
        .aluctrl   (aluctrl),
        .aluop1    (aluop1),
        .immop     (immop),
        .regop2    (regop2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .aluout    (aluout),
        .eq        (eq),
        .lt        (lt),
        .ltu       (ltu)
    );

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // RV32M-style arithmetic reference computed with wide integers.
    function automatic logic [31:0] refResult(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sa;
        longint          sb;
        longint unsigned ua;
        longint unsigned ub;
        logic [63:0]     t;
        logic signed [31:0] a32;
        logic [4:0]      s;
        logic            ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        a32 = a;
        s   = b[4:0];
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            5'd0:  return a + b;
            5'd1:  return a - b;
            5'd2:  return a & b;
            5'd3:  return a | b;
            5'd4:  return a ^ b;
            5'd5:  return a << s;
            5'd6:  return a >> s;
            5'd7:  return a32 >>> s;
            5'd8:  return (sa < sb) ? 32'd1 : 32'd0;
            5'd9:  return (ua < ub) ? 32'd1 : 32'd0;
            5'd16: begin t = sa * sb; return t[31:0]; end
            5'd17: begin t = sa * sb; return t[63:32]; end
            5'd18: begin t = sa * longint'(ua); return t[63:32]; end
            5'd19: begin t = ua * ub; return t[63:32]; end
            5'd20: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return 32'h8000_0000;
                t = sa / sb; return t[31:0];
            end
            5'd21: begin
                if (b == 0) return 32'hFFFF_FFFF;
                t = ua / ub; return t[31:0];
            end
            5'd22: begin
                if (b == 0) return a;
                if (ovf) return 32'd0;
                t = sa % sb; return t[31:0];
            end
            5'd23: begin
                if (b == 0) return a;
                t = ua % ub; return t[31:0];
            end
            default: return 32'd0;
        endcase
    endfunction

    // Edges from accept until out_valid is seen.
    function automatic int refLatency(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op < 5'd16 || op > 5'd23) return 1;
        if (op >= 5'd20 && b == 0) return 1;
        if ((op == 5'd20 || op == 5'd22) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return W + 2;
    endfunction

    function automatic logic [31:0] randOperand();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return $urandom_range(0, 15);
            default: return $urandom;
        endcase
    endfunction

    // Issue one request, check latency/result/flags, optionally stall the consumer.
    task automatic applyStimulus(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] imm,
                                 input logic [W-1:0] r2, input logic src, input int hold, input string tag);
        logic [W-1:0] b;
        logic [W-1:0] exp_res;
        int           edges;
        int           lim;
        b       = src ? imm : r2;
        exp_res = refResult(op, a, b);
        out_ready = (hold == 0);
        lim = 0;
        while (!in_ready && lim < 100) begin
            @(posedge clk); #1;
            lim++;
        end
        checkOutput({tag, "_rdy"}, 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        aluctrl  = op;
        aluop1   = a;
        immop    = imm;
        regop2   = r2;
        alusrc   = src;
        @(posedge clk); #1;
        in_valid = 1'b0;
        aluop1   = $urandom;
        immop    = $urandom;
        regop2   = $urandom;
        aluctrl  = 5'(OP_SUB);
        edges = 0;
        while (!out_valid && edges < 200) begin
            @(posedge clk); #1;
            edges++;
        end
        checkOutput({tag, "_lat"}, 64'(edges), 64'(refLatency(op, a, b)));
        checkOutput({tag, "_res"}, 64'(aluout), 64'(exp_res));
        checkOutput({tag, "_flags"}, 64'({eq, lt, ltu}),
                    64'({a == b, $signed(a) < $signed(b), a < b}));
        if (hold > 0) begin
            for (int i = 0; i < hold; i++) begin
                in_valid = 1'b1;
                aluctrl  = 5'(OP_ADD);
                aluop1   = 32'd1;
                regop2   = 32'd1;
                alusrc   = 1'b0;
                @(posedge clk); #1;
                checkOutput({tag, "_bp_valid"}, 64'(out_valid), 64'd1);
                checkOutput({tag, "_bp_res"}, 64'(aluout), 64'(exp_res));
                checkOutput({tag, "_bp_ready"}, 64'(in_ready), 64'd0);
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
        end
        @(posedge clk); #1;
        checkOutput({tag, "_idle_valid"}, 64'(out_valid), 64'd0);
        checkOutput({tag, "_idle_ready"}, 64'(in_ready), 64'd1);
        if (hold > 0) begin
            repeat (3) begin
                @(posedge clk); #1;
                checkOutput({tag, "_no_accept"}, 64'({out_valid, in_ready}), 64'b01);
            end
        end
    endtask

    initial begin
        logic [4:0]   rop;
        logic [W-1:0] ra;
        logic [W-1:0] ri;
        logic [W-1:0] rr;

        $display("[TB] start");
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_outs", 64'({in_ready, out_valid, eq, lt, ltu}), 64'b10000);
        checkOutput("reset_aluout", 64'(aluout), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        applyStimulus(5'(OP_ADD), 32'd5, 32'd7, 32'hDEAD_BEEF, 1'b1, 0, "add_imm");
        applyStimulus(5'(OP_MULH), 32'h8000_0000, 32'd0, 32'h8000_0000, 1'b0, 0, "mulh_neg");
        applyStimulus(5'(OP_MUL), 32'h8000_0000, 32'd0, 32'h8000_0000, 1'b0, 0, "mul_neg");
        applyStimulus(5'(OP_MULHU), 32'hFFFF_FFFF, 32'd0, 32'd2, 1'b0, 0, "mulhu");
        applyStimulus(5'(OP_DIV), -32'sd7, 32'd2, 32'd0, 1'b1, 0, "div_neg");
        applyStimulus(5'(OP_REM), -32'sd7, 32'd0, 32'd2, 1'b0, 0, "rem_neg");
        applyStimulus(5'(OP_DIVU), 32'd100, 32'd0, 32'd7, 1'b0, 0, "divu");
        applyStimulus(5'(OP_REMU), 32'd100, 32'd0, 32'd7, 1'b0, 0, "remu");
        applyStimulus(5'(OP_DIV), 32'd5, 32'd0, 32'd0, 1'b0, 0, "div_zero");
        applyStimulus(5'(OP_REM), 32'd5, 32'd0, 32'd0, 1'b0, 0, "rem_zero");
        applyStimulus(5'(OP_DIV), 32'h8000_0000, 32'd0, 32'hFFFF_FFFF, 1'b0, 0, "div_ovf");
        applyStimulus(5'(OP_SRA), 32'h8000_00F0, 32'd4, 32'd0, 1'b1, 0, "sra");
        applyStimulus(5'(12), 32'd9, 32'd0, 32'd9, 1'b0, 0, "unlisted");
        applyStimulus(5'(OP_XOR), 32'h1234_5678, 32'd0, 32'h0F0F_0F0F, 1'b0, 3, "backpressure");

        // Reset during an in-flight divide.
        in_valid = 1'b1;
        aluctrl  = 5'(OP_DIV);
        aluop1   = 32'd1000;
        regop2   = 32'd3;
        alusrc   = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        checkOutput("rst_mid_outs", 64'({in_ready, out_valid}), 64'b10);
        checkOutput("rst_mid_aluout", 64'(aluout), 64'd0);
        rst_n = 1'b1;
        applyStimulus(5'(OP_SUB), 32'd3, 32'd0, 32'd5, 1'b0, 0, "sub_after_rst");

        for (int i = 0; i < 40; i++) begin
            rop = op_list[$urandom_range(0, 21)];
            ra  = randOperand();
            ri  = randOperand();
            rr  = randOperand();
            applyStimulus(rop, ra, ri, rr, 1'($urandom_range(0, 1)), 0, $sformatf("rnd%0d_op%0d", i, rop));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
